seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Parametrised multi-cycle restoring divider, successor to the fixed 4-bit lab divider.
- Generalised operand width.
- Per-operation signed/unsigned mode.
- Explicit Busy status and divide-by-zero detection.
- Computes one quotient bit per clock.
- Sits behind a Go/ResultValid handshake in the lab datapaths.

Parameters:
WIDTH, 8, operand/result width in bits (legal: 2..32)
SIGNED_EN, 1, 1 = Signed input honoured; 0 = Signed input ignored, all operations unsigned

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-high reset
Go  in  1  start request; sampled only in S_IDLE
Signed  in  1  1 = two's-complement operation; captured with operands
Dividend  in  WIDTH  dividend; captured on accepting edge
Divisor  in  WIDTH  divisor; captured on accepting edge
Busy  out  1  high while an operation is in flight (any state except S_IDLE)
Quotient  out  WIDTH  registered quotient
Remainder  out  WIDTH  registered remainder
ResultValid  out  1  registered level; Quotient/Remainder hold a completed result
DivByZero  out  1  registered; last completed operation had Divisor == 0

Behaviour:
- Reset (async, any state):
  - State goes to S_IDLE.
  - Quotient, Remainder, ResultValid, DivByZero, Busy are all 0.
  - Internal registers are cleared.
  - An in-flight operation is abandoned.
- States: S_IDLE, S_DIVIDE, S_FIX.
- S_IDLE with Go=1 accepts an operation on that edge:
  - Captures Signed (forced 0 if SIGNED_EN=0).
  - Captures |Dividend| and |Divisor| as unsigned WIDTH-bit magnitudes, plus both sign bits.
  - Clears ResultValid and DivByZero.
  - Clears partial remainder A (WIDTH+1 bits) and the iteration counter ($clog2(WIDTH)+1 bits).
  - Next state is S_FIX if Divisor==0, else S_DIVIDE.
- S_IDLE with Go=0: hold state; all outputs hold.
- S_DIVIDE: each edge performs one restoring iteration:
  - Shift {A,Q} left by one.
  - Trial subtract the divisor magnitude from A.
  - If the result is negative, restore A and set Q LSB=0; otherwise keep the result and set Q LSB=1.
  - Counter increments.
  - After exactly WIDTH iterations, next state is S_FIX.
- S_FIX (one cycle): writes Quotient/Remainder and sets ResultValid=1; next state is S_IDLE.
  - Normal case: Quotient = Q, negated if the operand signs differ (signed mode).
  - Normal case: Remainder = A[WIDTH-1:0], negated if the dividend was negative (signed mode).
  - Division truncates toward zero; the remainder takes the sign of the dividend.
  - Divide-by-zero: Quotient = all ones, Remainder = raw Dividend as captured (pre-magnitude), DivByZero=1.
- Latency, from the accepting edge:
  - Normal: ResultValid rises WIDTH+1 edges later.
  - Divide-by-zero: ResultValid rises 1 edge later.
- ResultValid and results hold until the next accepted Go or Reset.
- Go while Busy=1 is ignored; no queuing.
- Go held high continuously: a new operation is accepted on the first edge in S_IDLE (the edge after S_FIX), so ResultValid pulses for exactly one cycle.
- Signed overflow (most-negative / -1): Quotient = most-negative value (wraps), Remainder = 0, DivByZero = 0; no separate flag.
- Operand inputs may change freely while Busy; only the accepting-edge values matter.

Decomposition:
- Package seq_divider_pkg holds:
  - typedef enum for the state (S_IDLE, S_DIVIDE, S_FIX).
  - Helper function abs_mag(value, signed_mode).
- Sub-module seq_divider_ctrl:
  - Contains the FSM and iteration counter.
  - Outputs: accept, step, fix, busy.
  - Inputs: go, div_zero.
- The datapath (magnitude registers, A/Q shift-subtract, sign fix-up, output registers) stays in seq_divider.

Test Plan:
(WIDTH=8, SIGNED_EN=1)
- Unsigned 200/7 (Signed=0) → Quotient=28, Remainder=4, ResultValid high exactly 9 edges after accept, Busy high for 9 cycles.
- Signed -7/2 (0xF9/0x02) → Quotient=0xFD (-3), Remainder=0xFF (-1); signed 7/-2 → Quotient=0xFD, Remainder=0x01.
- 0x55/0 → after 1 edge: Quotient=0xFF, Remainder=0x55, DivByZero=1; next op 9/3 → DivByZero=0, Quotient=3, Remainder=0.
- Signed -128/-1 (0x80/0xFF) → Quotient=0x80, Remainder=0x00, DivByZero=0; SIGNED_EN=0 instance, Signed=1, 0xF9/0x02 → Quotient=124, Remainder=1.
- Go pulsed mid-operation → ignored, first result unaffected.
- Reset asserted asynchronously mid-S_DIVIDE → all outputs 0 immediately, S_IDLE; a fresh 100/10 then gives Quotient=10, Remainder=0.
- Go held high across two ops (15/4 then 250/16) → ResultValid is a one-cycle pulse with Quotient=3, Remainder=3, then Quotient=15, Remainder=10.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_FIX
  } state_t;

  // Widest operand the divider supports; helpers work at this width.
  localparam int MAX_WIDTH = 32;

  // Magnitude of a sign-extended operand. In unsigned mode the value is
  // already a magnitude. The most-negative value maps onto itself, which
  // is the correct unsigned magnitude once truncated to the operand width.
  function automatic logic [MAX_WIDTH-1:0] abs_mag(input logic [MAX_WIDTH-1:0] value,
                                                   input logic                 signed_mode);
    return (signed_mode && value[MAX_WIDTH-1]) ? -value : value;
  endfunction

endpackage

// File: rtl/seq_divider_ctrl.sv
// Sequencer for the divider: idle/divide/fix FSM plus the iteration counter.
module seq_divider_ctrl
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic div_zero,
  output logic accept,
  output logic step,
  output logic fix,
  output logic busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] count;

  // Phase strobes for the datapath; accept must see go on the same edge.
  assign accept = (state == S_IDLE) && go;
  assign step   = (state == S_DIVIDE);
  assign fix    = (state == S_FIX);

  // State, iteration counter and busy flag advance together.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            count <= '0;
            busy  <= 1'b1;
            state <= div_zero ? S_FIX : S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          count <= count + 1'b1;
          if (count == LAST_ITER) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, with optional
// two's-complement operation and divide-by-zero reporting.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             result_valid,
  output logic             div_by_zero
);

  logic accept, step, fix;
  logic sign_eff, div_zero;

  logic [MAX_WIDTH-1:0] ext_dvd, ext_dvs;
  logic [WIDTH-1:0]     mag_dvd, mag_dvs;

  logic [WIDTH-1:0] mag_d;     // divisor magnitude
  logic [WIDTH-1:0] q_reg;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH:0]   a_reg;     // partial remainder
  logic [WIDTH-1:0] raw_dvd;   // dividend as presented, reported on divide-by-zero
  logic             neg_quot;  // operand signs differ
  logic             neg_rem;   // dividend was negative
  logic             dbz_op;    // operation in flight has a zero divisor

  logic [WIDTH:0]   shifted_a;
  logic [WIDTH+1:0] trial;

  assign sign_eff = signed_op && (SIGNED_EN != 0);
  assign div_zero = (divisor == '0);

  seq_divider_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .div_zero (div_zero),
    .accept   (accept),
    .step     (step),
    .fix      (fix),
    .busy     (busy)
  );

  // Extend operands to the helper width, sign-extending only in signed mode.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ext_dvd = '0;
    ext_dvs = '0;
    ext_dvd[WIDTH-1:0] = dividend;
    ext_dvs[WIDTH-1:0] = divisor;
    for (int i = WIDTH; i < MAX_WIDTH; i++) begin
      ext_dvd[i] = sign_eff & dividend[WIDTH-1];
      ext_dvs[i] = sign_eff & divisor[WIDTH-1];
    end
  end

  assign mag_dvd = WIDTH'(abs_mag(ext_dvd, sign_eff));
  assign mag_dvs = WIDTH'(abs_mag(ext_dvs, sign_eff));

  // One restoring step: shift {A,Q} left, trial-subtract the divisor.
  // The extra top bit of the trial result is its borrow/sign.
  assign shifted_a = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign trial     = {a_reg, q_reg[WIDTH-1]} - {2'b00, mag_d};

  // Operand capture, shift-subtract iterations and result write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_d        <= '0;
      q_reg        <= '0;
      a_reg        <= '0;
      raw_dvd      <= '0;
      neg_quot     <= 1'b0;
      neg_rem      <= 1'b0;
      dbz_op       <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      result_valid <= 1'b0;
      div_by_zero  <= 1'b0;
    end else begin
      if (accept) begin
        mag_d        <= mag_dvs;
        q_reg        <= mag_dvd;
        a_reg        <= '0;
        raw_dvd      <= dividend;
        neg_quot     <= sign_eff & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_rem      <= sign_eff & dividend[WIDTH-1];
        dbz_op       <= div_zero;
        result_valid <= 1'b0;
        div_by_zero  <= 1'b0;
      end
      if (step) begin
        a_reg <= trial[WIDTH+1] ? shifted_a : trial[WIDTH:0];
        q_reg <= {q_reg[WIDTH-2:0], ~trial[WIDTH+1]};
      end
      if (fix) begin
        result_valid <= 1'b1;
        if (dbz_op) begin
          quotient    <= '1;
          remainder   <= raw_dvd;
          div_by_zero <= 1'b1;
        end else begin
          quotient    <= neg_quot ? -q_reg : q_reg;
          remainder   <= neg_rem ? -a_reg[WIDTH-1:0] : a_reg[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): a signed-enabled instance
// checked through a scoreboard, plus a SIGNED_EN=0 instance on the same inputs.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic       signed_op;
  logic [7:0] dividend;
  logic [7:0] divisor;

  logic       busy, result_valid, div_by_zero;
  logic [7:0] quotient, remainder;
  logic       u_busy, u_result_valid, u_div_by_zero;
  logic [7:0] u_quotient, u_remainder;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8), .SIGNED_EN(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .go           (go),
    .signed_op    (signed_op),
    .dividend     (dividend),
    .divisor      (divisor),
    .busy         (busy),
    .quotient     (quotient),
    .remainder    (remainder),
    .result_valid (result_valid),
    .div_by_zero  (div_by_zero)
  );

  seq_divider #(.WIDTH(8), .SIGNED_EN(0)) dut_u (
    .clk          (clk),
    .reset        (reset),
    .go           (go),
    .signed_op    (signed_op),
    .dividend     (dividend),
    .divisor      (divisor),
    .busy         (u_busy),
    .quotient     (u_quotient),
    .remainder    (u_remainder),
    .result_valid (u_result_valid),
    .div_by_zero  (u_div_by_zero)
  );

  // Reference model using the simulator's integer division (truncates toward zero).
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
    exp_t e;
    int   ia, ib;
    if (b == 8'h00) begin
      e.q = 8'hFF; e.r = a; e.dbz = 1'b1;
      return e;
    end
    if (s) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
    end else begin
      ia = int'(a);
      ib = int'(b);
    end
    e.q = 8'(ia / ib);
    e.r = 8'(ia % ib);
    e.dbz = 1'b0;
    return e;
  endfunction

  // Present one operation for a single accepting edge; returns #1 after that edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    go        = 1'b1;
    sb.push_back(model(a, b, s));
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  // Wait (bounded) for result_valid; reports edges since accept and busy cycles.
  task automatic collect(output int lat, output int busy_cyc, output logic ok);
    lat      = 0;
    busy_cyc = busy ? 1 : 0;
    ok       = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (result_valid) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; go = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    #12;
    vectors++;
    if ({busy, result_valid, div_by_zero, quotient, remainder} !== 19'd0) begin
      $display("FAIL reset_outputs got %h want 0", {busy, result_valid, div_by_zero, quotient, remainder});
      miscompares++;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_unsigned;
    int lat, bc; logic ok; exp_t e;
    launch(8'd200, 8'd7, 1'b0);
    vectors++;
    if ({busy, result_valid} !== 2'b10) begin
      $display("FAIL accept_status got busy/valid %b want 10", {busy, result_valid});
      miscompares++;
    end
    collect(lat, bc, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok) begin $display("FAIL unsigned_timeout got none want result_valid"); miscompares++; end
    vectors++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      $display("FAIL unsigned_200_7 got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
      miscompares++;
    end
    vectors++;
    if (lat !== 9) begin $display("FAIL unsigned_latency got %0d want 9", lat); miscompares++; end
    vectors++;
    if (bc !== 9) begin $display("FAIL unsigned_busy_cycles got %0d want 9", bc); miscompares++; end
    @(posedge clk);
    #1;
    vectors++;
    if ({busy, result_valid, quotient} !== {1'b0, 1'b1, e.q}) begin
      $display("FAIL result_hold got busy=%b valid=%b q=%0d want 0 1 %0d", busy, result_valid, quotient, e.q);
      miscompares++;
    end
  endtask

  task automatic test_signed;
    int lat, bc; logic ok; exp_t e;
    logic [7:0] ops [2][2];
    ops[0][0] = 8'hF9; ops[0][1] = 8'h02;
    ops[1][0] = 8'h07; ops[1][1] = 8'hFE;
    for (int k = 0; k < 2; k++) begin
      launch(ops[k][0], ops[k][1], 1'b1);
      collect(lat, bc, ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
        $display("FAIL signed_op%0d got ok=%b q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                 k, ok, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        miscompares++;
      end
    end
  endtask

  task automatic test_div_zero;
    int lat, bc; logic ok; exp_t e;
    launch(8'h55, 8'h00, 1'b0);
    collect(lat, bc, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      $display("FAIL div_zero got ok=%b q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
               ok, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
      miscompares++;
    end
    vectors++;
    if (lat !== 1) begin $display("FAIL div_zero_latency got %0d want 1", lat); miscompares++; end
    launch(8'd9, 8'd3, 1'b0);
    vectors++;
    if (div_by_zero !== 1'b0) begin
      $display("FAIL dbz_cleared_on_accept got %b want 0", div_by_zero);
      miscompares++;
    end
    collect(lat, bc, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      $display("FAIL after_div_zero got ok=%b q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
               ok, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
      miscompares++;
    end
  endtask

  task automatic test_overflow_and_unsigned_inst;
    int lat, bc; logic ok; exp_t e, eu;
    launch(8'h80, 8'hFF, 1'b1);
    collect(lat, bc, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      $display("FAIL signed_overflow got ok=%b q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
               ok, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
      miscompares++;
    end
    // The SIGNED_EN=0 instance must treat this signed request as unsigned.
    eu = model(8'hF9, 8'h02, 1'b0);
    launch(8'hF9, 8'h02, 1'b1);
    collect(lat, bc, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || {quotient, remainder} !== {e.q, e.r}) begin
      $display("FAIL signed_inst_f9_02 got q=%h r=%h want q=%h r=%h", quotient, remainder, e.q, e.r);
      miscompares++;
    end
    vectors++;
    if ({u_result_valid, u_quotient, u_remainder, u_div_by_zero} !== {1'b1, eu.q, eu.r, 1'b0}) begin
      $display("FAIL unsigned_inst_f9_02 got v=%b q=%0d r=%0d dbz=%b want v=1 q=%0d r=%0d dbz=0",
               u_result_valid, u_quotient, u_remainder, u_div_by_zero, eu.q, eu.r);
      miscompares++;
    end
  endtask

  task automatic test_go_while_busy;
    int lat, bc; logic ok; exp_t e;
    launch(8'd200, 8'd7, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    dividend = 8'd9; divisor = 8'd3; go = 1'b1;
    @(negedge clk);
    go = 1'b0; dividend = 8'hAA; divisor = 8'h00;
    collect(lat, bc, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || {quotient, remainder} !== {e.q, e.r}) begin
      $display("FAIL go_while_busy got ok=%b q=%0d r=%0d want q=%0d r=%0d", ok, quotient, remainder, e.q, e.r);
      miscompares++;
    end
    repeat (12) @(posedge clk);
    #1;
    vectors++;
    if ({busy, result_valid, quotient} !== {1'b0, 1'b1, e.q}) begin
      $display("FAIL no_queued_op got busy=%b valid=%b q=%0d want 0 1 %0d", busy, result_valid, quotient, e.q);
      miscompares++;
    end
  endtask

  task automatic test_async_reset;
    int lat, bc; logic ok; exp_t e;
    launch(8'd200, 8'd7, 1'b0);
    void'(sb.pop_back());  // this operation is abandoned by reset
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({busy, result_valid, div_by_zero, quotient, remainder} !== 19'd0) begin
      $display("FAIL async_reset got %h want 0", {busy, result_valid, div_by_zero, quotient, remainder});
      miscompares++;
    end
    @(negedge clk);
    reset = 1'b0;
    launch(8'd100, 8'd10, 1'b0);
    collect(lat, bc, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || lat !== 9 || {quotient, remainder} !== {e.q, e.r}) begin
      $display("FAIL after_reset got ok=%b lat=%0d q=%0d r=%0d want lat=9 q=%0d r=%0d",
               ok, lat, quotient, remainder, e.q, e.r);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back;
    logic ok; exp_t e;
    @(negedge clk);
    dividend = 8'd15; divisor = 8'd4; signed_op = 1'b0; go = 1'b1;
    sb.push_back(model(8'd15, 8'd4, 1'b0));
    @(posedge clk);
    @(negedge clk);
    dividend = 8'd250; divisor = 8'd16;
    sb.push_back(model(8'd250, 8'd16, 1'b0));
    for (int op = 0; op < 2; op++) begin
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (result_valid) begin ok = 1'b1; break; end
      end
      e = sb.pop_front();
      vectors++;
      if (!ok || {quotient, remainder} !== {e.q, e.r}) begin
        $display("FAIL back_to_back_op%0d got ok=%b q=%0d r=%0d want q=%0d r=%0d",
                 op, ok, quotient, remainder, e.q, e.r);
        miscompares++;
      end
      if (op == 1) begin
        @(negedge clk);
        go = 1'b0;
      end
      @(posedge clk);
      #1;
      vectors++;
      if (result_valid !== (op == 1)) begin
        $display("FAIL back_to_back_valid%0d got %b want %b", op, result_valid, (op == 1));
        miscompares++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow_and_unsigned_inst();
    test_go_while_busy();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
